// File: rtl/lfsr_prbs_check.sv
// lfsr_prbs_check: PRBS checker for test-pattern lanes after a deserializer.
// A self-synchronising (feed-forward) LFSR turns each received word into a
// per-bit error vector. A small FSM seeds from the stream, acquires lock and
// then tracks it over fixed windows. Error bits are accumulated while locked.
// Optional build macro LFSR_PRBS_CHECK_STATS_EN: adds the locked word counter
// and makes err_cnt saturation sticky until err_clr. Without it word_cnt is 0.

module lfsr_prbs_check #(
    parameter int                    LFSR_WIDTH    = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
    parameter                        LFSR_CONFIG   = "FIBONACCI",
    parameter int                    REVERSE       = 0,
    parameter int                    INVERT        = 1,
    parameter int                    DATA_WIDTH    = 32,
    parameter                        STYLE         = "AUTO",
    parameter int                    LOCK_COUNT    = 16,
    parameter int                    WINDOW        = 64,
    parameter int                    UNLOCK_ERR    = 8,
    parameter int                    ERR_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    input  logic                     err_clr,
    output logic                     locked,
    output logic                     lock_lost,
    output logic [DATA_WIDTH-1:0]    err_bits,
    output logic                     err_word,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] word_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);
    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int PC_W   = $clog2(DATA_WIDTH + 1);
    localparam int SUM_W  = ((ERR_CNT_WIDTH > PC_W) ? ERR_CNT_WIDTH : PC_W) + 1;

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERR - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [SUM_W-1:0]  CNT_MAX   = SUM_W'({ERR_CNT_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t                  state_q, state_n;
    logic [GOOD_W-1:0]       good_q, good_n;
    logic [BAD_W-1:0]        bad_q, bad_n;
    logic [WIN_W-1:0]        win_q, win_n;
    logic                    lost_n;
    logic                    report;

    logic [LFSR_WIDTH-1:0]   state_reg;
    logic [DATA_WIDTH-1:0]   din_pol;
    logic [DATA_WIDTH-1:0]   core_din;
    logic [DATA_WIDTH-1:0]   core_err;
    logic [LFSR_WIDTH-1:0]   core_state;
    logic [DATA_WIDTH-1:0]   err_vec;
    logic                    word_bad;
    logic                    accept;
    logic                    count_en;
    logic [PC_W-1:0]         err_pc;
    logic [SUM_W-1:0]        cnt_sum;
    logic                    cnt_ovf;

    function automatic logic [PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    assign accept = data_in_valid & enable;

    // Input conditioning: optional ITU inversion, then optional bit reversal into the core.
    always_comb begin
        din_pol = (INVERT != 0) ? ~data_in : data_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            core_din[i] = (REVERSE != 0) ? din_pol[DATA_WIDTH-1-i] : din_pol[i];
        end
    end

    // Feed-forward LFSR core. data bit DATA_WIDTH-1 is the oldest bit on the line;
    // the state register only ever holds received bits, so one word re-seeds it.
    if (STYLE == "REDUCTION" && LFSR_CONFIG == "FIBONACCI") begin : g_core_red
        logic [LFSR_WIDTH+DATA_WIDTH-1:0] seq;
        assign seq = {state_reg, core_din};

        // Closed form: each error bit is the XOR of the bit and its tapped predecessors.
        always_comb begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                core_err[i] = seq[i] ^ seq[i+LFSR_WIDTH];
                for (int j = 1; j < LFSR_WIDTH; j++) begin
                    if (LFSR_POLY[j]) core_err[i] = core_err[i] ^ seq[i+j];
                end
            end
        end

        assign core_state = seq[LFSR_WIDTH-1:0];
    end else begin : g_core_loop
        // Bit-serial unrolled form, oldest bit first, Fibonacci or Galois taps.
        always_comb begin
            logic [LFSR_WIDTH-1:0] s;
            logic                  fb;
            s        = state_reg;
            core_err = '0;
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                fb = s[LFSR_WIDTH-1] ^ core_din[i];
                if (LFSR_CONFIG == "FIBONACCI") begin
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) fb = fb ^ s[j-1];
                    end
                    s = {s[LFSR_WIDTH-2:0], core_din[i]};
                end else begin
                    s = {s[LFSR_WIDTH-2:0], core_din[i]};
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) s[j] = s[j] ^ core_din[i];
                    end
                end
                core_err[i] = fb;
            end
            core_state = s;
        end
    end

    // Map the error vector back onto data_in bit positions.
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            err_vec[i] = (REVERSE != 0) ? core_err[DATA_WIDTH-1-i] : core_err[i];
        end
    end

    assign word_bad = |err_vec;

    // Next-state logic: seeding, lock acquisition and windowed loss-of-lock detection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n = state_q;
        good_n  = good_q;
        bad_n   = bad_q;
        win_n   = win_q;
        lost_n  = 1'b0;
        report  = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            good_n  = '0;
            bad_n   = '0;
            win_n   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_n = ST_SEED;
                end
                ST_SEED: begin
                    if (accept) begin
                        state_n = ST_ACQUIRE;
                        good_n  = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (accept) begin
                        report = 1'b1;
                        if (word_bad) begin
                            good_n = '0;
                        end else if (good_q == GOOD_LAST) begin
                            state_n = ST_LOCKED;
                            good_n  = '0;
                            bad_n   = '0;
                            win_n   = '0;
                        end else begin
                            good_n = good_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        report = 1'b1;
                        if (word_bad && (bad_q == BAD_LAST)) begin
                            // Loss of lock outranks a window wrap on the same word.
                            state_n = ST_ACQUIRE;
                            lost_n  = 1'b1;
                            good_n  = '0;
                            bad_n   = '0;
                            win_n   = '0;
                        end else if (win_q == WIN_LAST) begin
                            win_n = '0;
                            bad_n = '0;
                        end else begin
                            win_n = win_q + 1'b1;
                            if (word_bad) bad_n = bad_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and lock-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            good_q    <= '0;
            bad_q     <= '0;
            win_q     <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q   <= state_n;
            good_q    <= good_n;
            bad_q     <= bad_n;
            win_q     <= win_n;
            locked    <= (state_n == ST_LOCKED);
            lock_lost <= lost_n;
        end
    end

    // LFSR history and per-word error reporting; reports are suppressed while seeding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            err_bits  <= '0;
            err_word  <= 1'b0;
        end else begin
            if (accept) begin
                state_reg <= core_state;
                err_bits  <= report ? err_vec : '0;
            end else if (!enable) begin
                err_bits <= '0;
            end
            err_word <= report & word_bad;
        end
    end

    assign count_en = accept && (state_q == ST_LOCKED);
    assign err_pc   = popcount(err_vec);
    assign cnt_sum  = SUM_W'(err_cnt) + SUM_W'(err_pc);
    assign cnt_ovf  = (cnt_sum > CNT_MAX);

`ifdef LFSR_PRBS_CHECK_STATS_EN
    logic err_sat;

    // Error bit accumulator; once saturated it stays at all-ones until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_sat <= 1'b0;
        end else if (err_clr) begin
            err_cnt <= '0;
            err_sat <= 1'b0;
        end else if (count_en) begin
            if (err_sat || cnt_ovf) begin
                err_cnt <= '1;
                err_sat <= 1'b1;
            end else begin
                err_cnt <= cnt_sum[ERR_CNT_WIDTH-1:0];
            end
        end
    end

    // Saturating count of words checked while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (err_clr) begin
            word_cnt <= '0;
        end else if (count_en && (word_cnt != '1)) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end
`else
    // Saturating error bit accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (count_en) begin
            err_cnt <= cnt_ovf ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];
        end
    end

    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Testbench for lfsr_prbs_check: an independent serial PRBS31 transmitter model
// drives an inverted stream into two checkers (32-bit and 4-bit counters).

module tb_lfsr_prbs_check;

    localparam int DW = 32;
    localparam logic [DW-1:0] FLIP31 = 32'h8000_0000;
    localparam logic [DW-1:0] FLIP0  = 32'h0000_0001;
`ifdef LFSR_PRBS_CHECK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          err_clr = 1'b0;

    logic          locked, lock_lost, err_word;
    logic [DW-1:0] err_bits;
    logic [31:0]   err_cnt, word_cnt;
    logic          locked4, lock_lost4, err_word4;
    logic [DW-1:0] err_bits4;
    logic [3:0]    err_cnt4, word_cnt4;

    int     errors = 0;
    int     checks = 0;
    int     lost_seen = 0;
    int     errw_seen = 0;
    longint exp_err = 0;
    longint exp_wc = 0;
    logic [30:0] hist = '1;

    lfsr_prbs_check dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
        .data_in_valid(data_in_valid), .err_clr(err_clr), .locked(locked),
        .lock_lost(lock_lost), .err_bits(err_bits), .err_word(err_word),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    lfsr_prbs_check #(.ERR_CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
        .data_in_valid(data_in_valid), .err_clr(err_clr), .locked(locked4),
        .lock_lost(lock_lost4), .err_bits(err_bits4), .err_word(err_word4),
        .err_cnt(err_cnt4), .word_cnt(word_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    n;
        int    n_bad;
        bit    v;
        bit    en;
        bit    exp_locked;
        int    exp_lost;
        int    exp_errw;
        int    exp_dbits;
        int    exp_dwords;
    } seg_t;

    localparam int NSEG = 10;
    seg_t segs[NSEG];

    function automatic seg_t mk(input string name, input int n, input int n_bad,
                                input bit v, input bit en, input bit lk,
                                input int lost, input int errw, input int dbits,
                                input int dwords);
        seg_t s;
        s.name = name; s.n = n; s.n_bad = n_bad; s.v = v; s.en = en;
        s.exp_locked = lk; s.exp_lost = lost; s.exp_errw = errw;
        s.exp_dbits = dbits; s.exp_dwords = dwords;
        return s;
    endfunction

    function automatic logic [63:0] sat4(input longint v);
        return (v > 15) ? 64'd15 : 64'(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Transmitter: PRBS31 x^31+x^28+1, oldest bit in the MSB, sent inverted.
    task automatic gen(output logic [DW-1:0] w);
        logic p;
        for (int i = DW - 1; i >= 0; i--) begin
            p    = hist[30] ^ hist[27];
            hist = {hist[29:0], p};
            w[i] = p;
        end
        w = ~w;
    endtask

    task automatic apply(input logic v, input logic en, input logic clr, input logic [DW-1:0] flip);
        logic [DW-1:0] w;
        if (v) gen(w);
        else   w = DW'($urandom);
        data_in       = w ^ flip;
        data_in_valid = v;
        enable        = en;
        err_clr       = clr;
        @(posedge clk);
        #1;
        lost_seen += int'(lock_lost);
        errw_seen += int'(err_word);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".locked"},    locked,    0);
        check({tag, ".lock_lost"}, lock_lost, 0);
        check({tag, ".err_bits"},  err_bits,  0);
        check({tag, ".err_word"},  err_word,  0);
        check({tag, ".err_cnt"},   err_cnt,   0);
        check({tag, ".word_cnt"},  word_cnt,  0);
        check({tag, ".err_cnt4"},  err_cnt4,  0);
    endtask

    initial begin
        segs[0] = mk("win7_a",    64, 7,  1, 1, 1, 0, 7, 21, 64);
        segs[1] = mk("win7_b",    64, 7,  1, 1, 1, 0, 7, 21, 64);
        segs[2] = mk("win7_c",    64, 7,  1, 1, 1, 0, 7, 21, 64);
        segs[3] = mk("bad8",       8, 8,  1, 1, 0, 1, 8, 24, 8);
        segs[4] = mk("acq15",     15, 0,  1, 1, 0, 0, 0, 0,  0);
        segs[5] = mk("acq16",      1, 0,  1, 1, 1, 0, 0, 0,  0);
        segs[6] = mk("gap",       10, 10, 0, 1, 1, 0, 0, 0,  0);
        segs[7] = mk("disable",    3, 1,  1, 0, 0, 0, 0, 0,  0);
        segs[8] = mk("idle2seed",  1, 0,  0, 1, 0, 0, 0, 0,  0);
        segs[9] = mk("reseed",    17, 1,  1, 1, 1, 0, 0, 0,  0);

        // Reset state, then initial acquisition: lock on the 17th word after seeding starts.
        #12;
        check_all_zero("rst");
        #1 rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0, '0);
        lost_seen = 0;
        errw_seen = 0;
        for (int w = 1; w <= 17; w++) begin
            apply(1'b1, 1'b1, 1'b0, '0);
            if (w == 16) check("acq.locked_w16", locked, 0);
        end
        check("acq.locked_w17", locked, 1);
        check("acq.err_word_pulses", errw_seen, 0);
        check("acq.err_cnt", err_cnt, 0);

        // Table-driven segments.
        for (int s = 0; s < NSEG; s++) begin
            lost_seen = 0;
            errw_seen = 0;
            for (int k = 0; k < segs[s].n; k++) begin
                apply(segs[s].v, segs[s].en, 1'b0, (k < segs[s].n_bad) ? FLIP31 : '0);
            end
            exp_err += segs[s].exp_dbits;
            exp_wc  += segs[s].exp_dwords;
            check({segs[s].name, ".locked"},    locked,    segs[s].exp_locked);
            check({segs[s].name, ".lost"},      lost_seen, segs[s].exp_lost);
            check({segs[s].name, ".err_words"}, errw_seen, segs[s].exp_errw);
            check({segs[s].name, ".err_cnt"},   err_cnt,   exp_err);
            check({segs[s].name, ".err_cnt4"},  err_cnt4,  sat4(exp_err));
            check({segs[s].name, ".word_cnt"},  word_cnt,  STATS ? exp_wc : 0);
            check({segs[s].name, ".word_cnt4"}, word_cnt4, STATS ? sat4(exp_wc) : 0);
        end

        // Single line-bit errors: bit 31 echoes inside its own word, bit 0 spills into the next.
        errw_seen = 0;
        apply(1'b1, 1'b1, 1'b0, FLIP31);
        check("flip31.err_bits", err_bits, 32'h8000_0009);
        check("flip31.err_word", err_word, 1);
        apply(1'b1, 1'b1, 1'b0, '0);
        check("flip31.next_err_bits", err_bits, 0);
        apply(1'b1, 1'b1, 1'b0, FLIP0);
        check("flip0.err_bits", err_bits, 32'h0000_0001);
        apply(1'b1, 1'b1, 1'b0, '0);
        check("flip0.next_err_bits", err_bits, 32'h0000_0012);
        check("flip0.next_err_word", err_word, 1);
        exp_err += 6;
        exp_wc  += 4;
        check("flips.err_word_pulses", errw_seen, 3);
        check("flips.err_cnt", err_cnt, exp_err);
        check("flips.locked", locked, 1);

        // err_clr beats a simultaneous errored word; the 4-bit counter is saturated first.
        check("sat4.err_cnt4", err_cnt4, 15);
        apply(1'b1, 1'b1, 1'b1, FLIP31);
        check("clr.err_cnt", err_cnt, 0);
        check("clr.err_cnt4", err_cnt4, 0);
        check("clr.word_cnt", word_cnt, 0);
        apply(1'b1, 1'b1, 1'b0, FLIP31);
        check("post_clr.err_cnt", err_cnt, 3);
        check("post_clr.err_cnt4", err_cnt4, 3);
        check("post_clr.word_cnt", word_cnt, STATS ? 1 : 0);

        // Gaps hold everything.
        errw_seen = 0;
        for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, 1'b0, FLIP31);
        check("hold.err_cnt", err_cnt, 3);
        check("hold.locked", locked, 1);
        check("hold.err_word_pulses", errw_seen, 0);
        check("hold.word_cnt", word_cnt, STATS ? 1 : 0);

        // Asynchronous reset mid-cycle, then re-seed and relock.
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0, '0);
        for (int w = 1; w <= 17; w++) begin
            apply(1'b1, 1'b1, 1'b0, '0);
            if (w == 16) check("relock.locked_w16", locked, 0);
        end
        check("relock.locked_w17", locked, 1);
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b1, 1'b0, '0);
        check("relock.word_cnt", word_cnt, STATS ? 5 : 0);
        check("relock.err_cnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
